// File: rtl/sensor_conditioner_pkg.sv
// Shared definitions for the vehicle loop-detector conditioner: channel state
// encoding, default timing constants and a presence decode helper.
package sensor_conditioner_pkg;

    localparam int DEF_SAMPLE_DIV   = 100_000;
    localparam int DEF_DEBOUNCE_CNT = 20;
    localparam int DEF_HOLD_CNT     = 2000;
    localparam int DEF_STUCK_CNT    = 120_000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_QUAL_ON  = 3'd1,
        ST_ON       = 3'd2,
        ST_QUAL_OFF = 3'd3,
        ST_HOLD     = 3'd4,
        ST_FAULT    = 3'd5
    } ch_state_e;

    // A vehicle is reported present from qualification until the hold expires.
    function automatic logic is_present(ch_state_e s);
        return (s == ST_ON) || (s == ST_QUAL_OFF) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Signal bundle between the loop detectors, the conditioner and the light controller.
interface sensor_conditioner_if;
    import sensor_conditioner_pkg::*;

    // No valid/ready handshake: raw inputs and presence outputs are levels sampled
    // every cycle; *_arrive are single-cycle strobes, *_fault are sticky levels.
    logic      enable;
    logic      sa_raw;
    logic      sb_raw;
    logic      Sa;
    logic      Sb;
    logic      sa_arrive;
    logic      sb_arrive;
    logic      sa_fault;
    logic      sb_fault;
    ch_state_e sa_state;
    ch_state_e sb_state;

    modport master (
        output enable, sa_raw, sb_raw,
        input  Sa, Sb, sa_arrive, sb_arrive, sa_fault, sb_fault, sa_state, sb_state
    );

    modport slave (
        input  enable, sa_raw, sb_raw,
        output Sa, Sb, sa_arrive, sb_arrive, sa_fault, sb_fault, sa_state, sb_state
    );

endinterface

// File: rtl/sensor_conditioner_channel.sv
// One detector channel: 2-flop synchronizer, debounce/hold/stuck counters and the
// presence FSM. All counting happens only on sample ticks.
module sensor_channel
    import sensor_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int HOLD_CNT     = DEF_HOLD_CNT,
    parameter int STUCK_CNT    = DEF_STUCK_CNT
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      enable,
    input  logic      tick,
    input  logic      raw_async,
    output logic      presence,
    output logic      arrive,
    output logic      fault,
    output ch_state_e state
);

    localparam int QUAL_MAX = (DEBOUNCE_CNT > HOLD_CNT) ? DEBOUNCE_CNT : HOLD_CNT;
    localparam int CNT_W    = $clog2(QUAL_MAX) + 1;
    localparam int STUCK_W  = $clog2(STUCK_CNT) + 1;

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   DEB_LIM   = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0]   HOLD_LIM  = CNT_W'(HOLD_CNT);
    localparam logic [STUCK_W-1:0] STUCK_ONE = STUCK_W'(1);
    localparam logic [STUCK_W-1:0] STUCK_LIM = STUCK_W'(STUCK_CNT);

    logic [1:0]         sync_q, sync_d;
    ch_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [STUCK_W-1:0] stuck_q, stuck_d, stuck_inc;
    logic               presence_q, presence_d;
    logic               arrive_q, arrive_d;
    logic               fault_q, fault_d;
    logic               raw;

    assign raw = sync_q[1];

    always_comb begin
        sync_d     = {sync_q[0], raw_async};
        state_d    = state_q;
        cnt_d      = cnt_q;
        stuck_d    = stuck_q;
        cnt_inc    = (&cnt_q)   ? cnt_q   : cnt_q + CNT_ONE;
        stuck_inc  = (&stuck_q) ? stuck_q : stuck_q + STUCK_ONE;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            stuck_d = '0;
        end else if (tick) begin
            // A raw change is always tested before a count completes, so a change
            // on the completing tick wins.
            unique case (state_q)
                ST_IDLE: begin
                    stuck_d = '0;
                    if (raw) begin
                        state_d = ST_QUAL_ON;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_QUAL_ON: begin
                    if (!raw) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc >= DEB_LIM) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        stuck_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_ON: begin
                    if (!raw) begin
                        state_d = ST_QUAL_OFF;
                        cnt_d   = CNT_ONE;
                    end else begin
                        stuck_d = stuck_inc;
                        if (stuck_inc >= STUCK_LIM) begin
                            state_d = ST_FAULT;
                        end
                    end
                end
                ST_QUAL_OFF: begin
                    if (raw) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else if (cnt_inc >= DEB_LIM) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HOLD: begin
                    // Re-detection during the hold is a fresh vehicle for stuck purposes.
                    if (raw) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        stuck_d = '0;
                    end else if (cnt_inc >= HOLD_LIM) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    stuck_d = '0;
                end
            endcase
        end

        presence_d = is_present(state_d);
        arrive_d   = presence_d & ~presence_q;
        fault_d    = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            stuck_q    <= '0;
            presence_q <= 1'b0;
            arrive_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stuck_q    <= stuck_d;
            presence_q <= presence_d;
            arrive_q   <= arrive_d;
            fault_q    <= fault_d;
        end
    end

    assign presence = presence_q;
    assign arrive   = arrive_q;
    assign fault    = fault_q;
    assign state    = state_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Two-channel loop-detector conditioner: shared sample prescaler plus two
// independent sensor_channel instances feeding the light controller.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int HOLD_CNT     = DEF_HOLD_CNT,
    parameter int STUCK_CNT    = DEF_STUCK_CNT
) (
    input logic                 clk,
    input logic                 reset,
    sensor_conditioner_if.slave bus
);

    localparam int                 PRESC_W    = $clog2(SAMPLE_DIV) + 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;
    logic               sa_pres, sb_pres, sa_arr, sb_arr, sa_flt, sb_flt;
    ch_state_e          sa_st, sb_st;

    // Disabling parks the prescaler at zero so re-enable starts a full sample period.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (!bus.enable) begin
            presc_d = '0;
        end else if (presc_q >= PRESC_LAST) begin
            presc_d = '0;
            tick    = 1'b1;
        end else begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    sensor_channel #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .HOLD_CNT     (HOLD_CNT),
        .STUCK_CNT    (STUCK_CNT)
    ) u_chan_a (
        .clk       (clk),
        .reset     (reset),
        .enable    (bus.enable),
        .tick      (tick),
        .raw_async (bus.sa_raw),
        .presence  (sa_pres),
        .arrive    (sa_arr),
        .fault     (sa_flt),
        .state     (sa_st)
    );

    sensor_channel #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .HOLD_CNT     (HOLD_CNT),
        .STUCK_CNT    (STUCK_CNT)
    ) u_chan_b (
        .clk       (clk),
        .reset     (reset),
        .enable    (bus.enable),
        .tick      (tick),
        .raw_async (bus.sb_raw),
        .presence  (sb_pres),
        .arrive    (sb_arr),
        .fault     (sb_flt),
        .state     (sb_st)
    );

    assign bus.Sa        = sa_pres;
    assign bus.Sb        = sb_pres;
    assign bus.sa_arrive = sa_arr;
    assign bus.sb_arrive = sb_arr;
    assign bus.sa_fault  = sa_flt;
    assign bus.sb_fault  = sb_flt;
    assign bus.sa_state  = sa_st;
    assign bus.sb_state  = sb_st;

endmodule
